apb_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single apb_master external request interface between NUM_REQ requesters (frame decoder, config sources).
- Latches the winning request, holds it on the master until master_ready, returns read data to the winner, and aborts hung transfers on timeout.
- Sits between the requesters and apb_master; apb_slave and the UART path downstream are unchanged.

---
 rtl/apb_req_arbiter_pkg.sv | 15 +
 rtl/apb_req_arbiter_if.sv | 43 ++++
 rtl/apb_req_arbiter_rr_pick.sv | 29 ++
 rtl/apb_req_arbiter.sv | 131 +++++++++++++
 tb/tb_apb_req_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the APB request arbiter: bus field widths and FSM state codes.
package apb_arb_pkg;

    localparam int PSEL_W = 7;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 2;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_WAIT = 2'd1;
    localparam arb_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of requester-side and apb_master-side signals around the request arbiter.
interface apb_req_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*PSEL_W-1:0] req_psel;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0] req_strobe;
    logic [NUM_REQ-1:0]        req_done;
    logic                      req_err;
    logic [DATA_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        grant;

    logic                      m_valid;
    logic [PSEL_W-1:0]         m_psel;
    logic                      m_write;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [STRB_W-1:0]         m_strobe;
    logic                      m_ready;
    logic [DATA_W-1:0]         m_rdata;

    // The arbiter is the slave of its requesters and drives apb_master.
    modport slave (
        input  req_valid, req_psel, req_write, req_addr, req_wdata, req_strobe,
        input  m_ready, m_rdata,
        output req_done, req_err, req_rdata, grant,
        output m_valid, m_psel, m_write, m_addr, m_wdata, m_strobe
    );

    modport master (
        output req_valid, req_psel, req_write, req_addr, req_wdata, req_strobe,
        output m_ready, m_rdata,
        input  req_done, req_err, req_rdata, grant,
        input  m_valid, m_psel, m_write, m_addr, m_wdata, m_strobe
    );

endinterface

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);

    always_comb begin
        int j;
        j       = 0;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found      = 1'b1;
                win_oh[j]  = 1'b1;
                win_idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master request port between NUM_REQ requesters,
// with per-transfer timeout abort. All outputs are registered.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input logic              clk,
    input logic              rst,
    apb_req_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic [TO_W-1:0]     to_cnt;

    logic [NUM_REQ-1:0]  grant_r;
    logic [NUM_REQ-1:0]  done_r;
    logic                err_r;
    logic [DATA_W-1:0]   rdata_r;

    logic                m_valid_r;
    logic [PSEL_W-1:0]   m_psel_r;
    logic                m_write_r;
    logic [ADDR_W-1:0]   m_addr_r;
    logic [DATA_W-1:0]   m_wdata_r;
    logic [STRB_W-1:0]   m_strobe_r;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                timed_out;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .found   (pick_any)
    );

    // The first WAIT cycle sees to_cnt=0, so the abort is taken TIMEOUT+1 cycles
    // after m_valid rises; this is why TO_W must be able to hold TIMEOUT itself.
    assign timed_out = (to_cnt == TO_W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            to_cnt     <= '0;
            grant_r    <= '0;
            done_r     <= '0;
            err_r      <= 1'b0;
            rdata_r    <= '0;
            m_valid_r  <= 1'b0;
            m_psel_r   <= '0;
            m_write_r  <= 1'b0;
            m_addr_r   <= '0;
            m_wdata_r  <= '0;
            m_strobe_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_idx  <= pick_idx;
                        grant_r    <= pick_oh;
                        m_valid_r  <= 1'b1;
                        m_psel_r   <= bus.req_psel[int'(pick_idx)*PSEL_W +: PSEL_W];
                        m_write_r  <= bus.req_write[pick_idx];
                        m_addr_r   <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        m_wdata_r  <= bus.req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        m_strobe_r <= bus.req_strobe[int'(pick_idx)*STRB_W +: STRB_W];
                        to_cnt     <= '0;
                        state      <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // A completion arriving on the expiry cycle still counts as success.
                    if (bus.m_ready) begin
                        rdata_r   <= bus.m_rdata;
                        err_r     <= 1'b0;
                        m_valid_r <= 1'b0;
                        done_r    <= grant_r;
                        state     <= ST_DONE;
                    end else if (timed_out) begin
                        rdata_r   <= '0;
                        err_r     <= 1'b1;
                        m_valid_r <= 1'b0;
                        done_r    <= grant_r;
                        state     <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    done_r  <= '0;
                    grant_r <= '0;
                    rr_ptr  <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = grant_r;
    assign bus.req_done  = done_r;
    assign bus.req_err   = err_r;
    assign bus.req_rdata = rdata_r;
    assign bus.m_valid   = m_valid_r;
    assign bus.m_psel    = m_psel_r;
    assign bus.m_write   = m_write_r;
    assign bus.m_addr    = m_addr_r;
    assign bus.m_wdata   = m_wdata_r;
    assign bus.m_strobe  = m_strobe_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int TIMEOUT = 8;
    localparam int TO_W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    apb_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    apb_req_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: who owns the port, how long it has waited, and what each
    // output must read in the current cycle.
    int                 md_owner;
    int                 md_waited;
    bit                 md_done;
    int                 md_ptr;
    logic               e_mvalid;
    logic [NUM_REQ-1:0] e_grant;
    logic [NUM_REQ-1:0] e_done;
    logic               e_err;
    logic [31:0]        e_rdata;
    logic [6:0]         e_psel;
    logic               e_write;
    logic [31:0]        e_addr;
    logic [31:0]        e_wdata;
    logic [1:0]         e_strobe;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        md_owner  = -1;
        md_waited = 0;
        md_done   = 1'b0;
        md_ptr    = 0;
        e_mvalid  = 1'b0;
        e_grant   = '0;
        e_done    = '0;
        e_err     = 1'b0;
        e_rdata   = '0;
        e_psel    = '0;
        e_write   = 1'b0;
        e_addr    = '0;
        e_wdata   = '0;
        e_strobe  = '0;
    endtask

    task automatic modelAdvance();
        int  i;
        bit  finish;
        finish = 1'b0;
        if (md_done) begin
            e_done   = '0;
            e_grant  = '0;
            md_ptr   = (md_owner + 1) % NUM_REQ;
            md_owner = -1;
            md_done  = 1'b0;
        end else if (md_owner >= 0) begin
            if (bus.m_ready) begin
                e_rdata = bus.m_rdata;
                e_err   = 1'b0;
                finish  = 1'b1;
            end else if (md_waited == TIMEOUT) begin
                e_rdata = '0;
                e_err   = 1'b1;
                finish  = 1'b1;
            end else begin
                md_waited++;
            end
            if (finish) begin
                e_mvalid = 1'b0;
                e_done   = NUM_REQ'(1) << md_owner;
                md_done  = 1'b1;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                i = (md_ptr + k) % NUM_REQ;
                if (bus.req_valid[i]) begin
                    md_owner  = i;
                    md_waited = 0;
                    e_mvalid  = 1'b1;
                    e_grant   = NUM_REQ'(1) << i;
                    e_psel    = bus.req_psel[i*PSEL_W +: PSEL_W];
                    e_write   = bus.req_write[i];
                    e_addr    = bus.req_addr[i*ADDR_W +: ADDR_W];
                    e_wdata   = bus.req_wdata[i*DATA_W +: DATA_W];
                    e_strobe  = bus.req_strobe[i*STRB_W +: STRB_W];
                    break;
                end
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("m_valid",   bus.m_valid,   e_mvalid);
        checkOutput("grant",     bus.grant,     e_grant);
        checkOutput("req_done",  bus.req_done,  e_done);
        checkOutput("req_err",   bus.req_err,   e_err);
        checkOutput("req_rdata", bus.req_rdata, e_rdata);
        checkOutput("m_psel",    bus.m_psel,    e_psel);
        checkOutput("m_write",   bus.m_write,   e_write);
        checkOutput("m_addr",    bus.m_addr,    e_addr);
        checkOutput("m_wdata",   bus.m_wdata,   e_wdata);
        checkOutput("m_strobe",  bus.m_strobe,  e_strobe);
    endtask

    // Inputs only change just after rising edges, so mid-cycle they are exactly
    // what the next rising edge will sample.
    initial begin
        modelReset();
        forever begin
            @(negedge clk);
            if (rst) begin
                modelReset();
                compareAll();
            end else begin
                compareAll();
                modelAdvance();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic randFields(input int i);
        bus.req_psel[i*PSEL_W +: PSEL_W]   = 7'($urandom());
        bus.req_write[i]                   = 1'($urandom());
        bus.req_addr[i*ADDR_W +: ADDR_W]   = $urandom();
        bus.req_wdata[i*DATA_W +: DATA_W]  = $urandom();
        bus.req_strobe[i*STRB_W +: STRB_W] = 2'($urandom());
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i]) begin
                if (bus.req_done[i]) begin
                    if ($urandom_range(0, 2) != 0) bus.req_valid[i] = 1'b0;
                    else randFields(i);
                end else if ($urandom_range(0, 63) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    bus.req_addr[i*ADDR_W +: ADDR_W] = $urandom();
                end
            end else if ($urandom_range(0, 2) == 0) begin
                randFields(i);
                bus.req_valid[i] = 1'b1;
            end
        end
        bus.m_ready = ($urandom_range(0, 3) == 0);
        bus.m_rdata = $urandom();
    endtask

    task automatic waitGrant(input string name);
        int n;
        n = 0;
        while (bus.m_valid !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        checkOutput(name, bus.m_valid, 1'b1);
    endtask

    int exp_g [4] = '{2, 1, 2, 1};
    int lat;

    initial begin
        bus.req_valid  = '0;
        bus.req_psel   = '0;
        bus.req_write  = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_strobe = '0;
        bus.m_ready    = 1'b0;
        bus.m_rdata    = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_m_valid", bus.m_valid, 1'b0);
        checkOutput("rst_grant", bus.grant, '0);
        checkOutput("rst_req_done", bus.req_done, '0);
        checkOutput("rst_req_err", bus.req_err, 1'b0);
        checkOutput("rst_m_addr", bus.m_addr, '0);
        rst = 1'b0;

        $display("[TB] single read");
        bus.req_psel[6:0]   = 7'h05;
        bus.req_addr[31:0]  = 32'h10;
        bus.req_write[0]    = 1'b0;
        bus.req_strobe[1:0] = 2'b11;
        bus.req_valid       = 3'b001;
        cyc();
        checkOutput("t1_m_valid", bus.m_valid, 1'b1);
        checkOutput("t1_grant", bus.grant, 3'b001);
        checkOutput("t1_m_psel", bus.m_psel, 7'h05);
        for (int k = 0; k < 4; k++) begin
            cyc();
            checkOutput("t1_m_addr_stable", bus.m_addr, 32'h10);
        end
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hDEADBEEF;
        cyc();
        bus.m_ready   = 1'b0;
        bus.req_valid = 3'b000;
        checkOutput("t1_req_done", bus.req_done, 3'b001);
        checkOutput("t1_req_rdata", bus.req_rdata, 32'hDEADBEEF);
        checkOutput("t1_req_err", bus.req_err, 1'b0);
        checkOutput("t1_m_valid_low", bus.m_valid, 1'b0);
        cyc();
        checkOutput("t1_done_cleared", bus.req_done, '0);
        checkOutput("t1_grant_cleared", bus.grant, '0);

        $display("[TB] contention");
        bus.req_addr[63:32] = 32'h20;
        bus.req_valid       = 3'b011;
        for (int t = 0; t < 4; t++) begin
            waitGrant("t2_granted");
            checkOutput("t2_grant", bus.grant, 3'(exp_g[t]));
            cyc();
            bus.m_ready = 1'b1;
            bus.m_rdata = 32'(t);
            cyc();
            bus.m_ready = 1'b0;
            checkOutput("t2_req_done", bus.req_done, 3'(exp_g[t]));
        end

        $display("[TB] timeout");
        bus.req_valid = 3'b001;
        waitGrant("t3_granted");
        checkOutput("t3_grant", bus.grant, 3'b001);
        lat = 0;
        while (bus.req_done === '0 && lat < 30) begin
            cyc();
            lat++;
        end
        checkOutput("t3_latency", 64'(lat), 64'd9);
        checkOutput("t3_req_err", bus.req_err, 1'b1);
        checkOutput("t3_req_rdata", bus.req_rdata, '0);
        bus.req_valid = 3'b011;

        $display("[TB] ready on expiry cycle");
        waitGrant("t4_granted");
        checkOutput("t4_grant_advanced", bus.grant, 3'b010);
        repeat (TIMEOUT) cyc();
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h12345678;
        cyc();
        bus.m_ready   = 1'b0;
        bus.req_valid = 3'b000;
        checkOutput("t4_req_done", bus.req_done, 3'b010);
        checkOutput("t4_req_err", bus.req_err, 1'b0);
        checkOutput("t4_req_rdata", bus.req_rdata, 32'h12345678);
        cyc();
        bus.m_ready = 1'b1;
        cyc();
        cyc();
        checkOutput("t4_spurious_done", bus.req_done, '0);
        checkOutput("t4_spurious_m_valid", bus.m_valid, 1'b0);
        bus.m_ready = 1'b0;

        $display("[TB] reset during wait");
        bus.req_valid = 3'b001;
        waitGrant("t5_granted");
        checkOutput("t5_grant", bus.grant, 3'b001);
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_m_valid", bus.m_valid, 1'b0);
        checkOutput("t5_rst_grant", bus.grant, '0);
        checkOutput("t5_rst_done", bus.req_done, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid = 3'b011;
        waitGrant("t5_regranted");
        checkOutput("t5_ptr_reset_grant", bus.grant, 3'b001);
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        checkOutput("t5_req_done", bus.req_done, 3'b001);
        bus.req_valid       = 3'b010;
        bus.req_addr[63:32] = 32'hA5;

        $display("[TB] withdrawal");
        waitGrant("t6_granted");
        checkOutput("t6_grant", bus.grant, 3'b010);
        bus.req_valid       = 3'b000;
        bus.req_addr[63:32] = 32'hFFFF;
        cyc();
        cyc();
        checkOutput("t6_m_addr_held", bus.m_addr, 32'hA5);
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        checkOutput("t6_req_done", bus.req_done, 3'b010);
        cyc();

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            cyc();
        end
        bus.req_valid = '0;
        bus.m_ready   = 1'b0;
        repeat (30) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
